// File: rtl/link_pkg.sv
// Shared link definitions: CRC-16/CCITT-FALSE constants, transmit FSM states, byte-wise CRC step.
// Combinational helpers only; no latency.
// No flow control here; callers decide when a byte counts.
package link_pkg;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        PAYLOAD,
        CRC_HI,
        CRC_LO,
        GAP
    } tx_state_t;

    // MSB-first, unreflected; the receive-side checker uses the same step.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/prbs16.sv
// 16-bit Fibonacci LFSR payload source, reset to seed.
// Current and next-state bytes are available in the same cycle; advances one step per cycle when asked.
// The caller holds advance low while its output is stalled.
module prbs16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [7:0]  cur_byte,
    output logic [7:0]  next_byte
);

    logic [15:0] lfsr;
    logic [15:0] lfsr_next;

    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign cur_byte  = lfsr[7:0];
    assign next_byte = lfsr_next[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= seed;
        end else if (advance) begin
            lfsr <= lfsr_next;
        end
    end

endmodule

// File: rtl/frame_tx.sv
// Fixed-length frame generator: payload (PRBS or incrementing) + CRC-16, optional CRC corruption.
// First byte presented the cycle after enable is seen idle; one byte per cycle while tx_ready is high.
// On tx_ready low all outputs hold and the LFSR/CRC freeze.
module frame_tx
    import link_pkg::*;
#(
    parameter int          PAYLOAD_BYTES = 9,
    parameter int          GAP_CYCLES    = 2,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        pattern_mode,
    input  logic        inject_err,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_sof,
    output logic        tx_eof,
    output logic        busy,
    output logic [31:0] frames_sent,
    output logic [31:0] frames_corrupted
);

    localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_BYTES - 1);
    localparam logic [7:0] INC_BASE = 8'h31;

    tx_state_t   state;
    logic [7:0]  idx;
    logic        mode;
    logic [15:0] crc;
    logic [15:0] crc_next;
    logic        pending;
    logic        corrupt;
    logic [15:0] gap_cnt;
    logic [7:0]  prbs_cur;
    logic [7:0]  prbs_next;
    logic        accept;
    logic        sof_accept;
    logic        frame_done;
    logic        gap_last;
    logic        start;
    logic        advance;

    assign accept     = tx_valid && tx_ready;
    assign sof_accept = accept && tx_sof;
    assign frame_done = accept && (state == CRC_LO);
    assign advance    = accept && (state == PAYLOAD) && !mode;
    assign crc_next   = crc16_byte(crc, tx_data);
    assign gap_last   = (state == GAP) && (gap_cnt == 16'(GAP_CYCLES - 1));
    assign busy       = (state == PAYLOAD) || (state == CRC_HI) || (state == CRC_LO);

    // The last gap cycle (or the CRC_LO accept when there is no gap) acts as
    // IDLE, so back-to-back frames are separated by exactly GAP_CYCLES idle cycles.
    assign start = enable && ((state == IDLE) || gap_last || (frame_done && (GAP_CYCLES == 0)));

    prbs16 u_prbs (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed      (LFSR_SEED),
        .advance   (advance),
        .cur_byte  (prbs_cur),
        .next_byte (prbs_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            idx              <= 8'd0;
            mode             <= 1'b0;
            crc              <= CRC16_INIT;
            pending          <= 1'b0;
            corrupt          <= 1'b0;
            gap_cnt          <= 16'd0;
            tx_valid         <= 1'b0;
            tx_data          <= 8'd0;
            tx_sof           <= 1'b0;
            tx_eof           <= 1'b0;
            frames_sent      <= 32'd0;
            frames_corrupted <= 32'd0;
        end else begin
            // A pulse landing on the SOF accept belongs to the following frame.
            pending <= sof_accept ? inject_err : (pending | inject_err);
            if (sof_accept) begin
                corrupt <= pending;
            end

            case (state)
                PAYLOAD: begin
                    if (accept) begin
                        crc    <= crc_next;
                        tx_sof <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state   <= CRC_HI;
                            tx_data <= crc_next[15:8];
                        end else begin
                            idx     <= idx + 8'd1;
                            tx_data <= mode ? (INC_BASE + idx + 8'd1) : prbs_next;
                        end
                    end
                end
                CRC_HI: begin
                    if (accept) begin
                        state   <= CRC_LO;
                        tx_data <= crc[7:0] ^ {7'b0, corrupt};
                        tx_eof  <= 1'b1;
                    end
                end
                CRC_LO: begin
                    if (accept) begin
                        frames_sent <= frames_sent + 32'd1;
                        if (corrupt) begin
                            frames_corrupted <= frames_corrupted + 32'd1;
                        end
                        tx_valid <= 1'b0;
                        tx_eof   <= 1'b0;
                        gap_cnt  <= 16'd0;
                        state    <= (GAP_CYCLES > 0) ? GAP : IDLE;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 16'd1;
                    if (gap_last) begin
                        state <= IDLE;
                    end
                end
                default: ;
            endcase

            if (start) begin
                state    <= PAYLOAD;
                idx      <= 8'd0;
                mode     <= pattern_mode;
                crc      <= CRC16_INIT;
                tx_valid <= 1'b1;
                tx_sof   <= 1'b1;
                tx_eof   <= 1'b0;
                tx_data  <= pattern_mode ? INC_BASE : prbs_cur;
            end
        end
    end

endmodule
